// File: rtl/fifo_sched_pkg.sv
// Shared types and default sizing for the round-robin FIFO drain scheduler.
// The SCHED_PRIO_EN macro only affects fifo_rr_pick.
package fifo_sched_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int NUM_QUEUES_DEF = 4;
  localparam int QUEUE_BITS_DEF = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    HOLD
  } state_e;

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational next-grant search over the non-empty queues.
// SCHED_PRIO_EN: queue 0 wins whenever non-empty and flags prio_o.
module fifo_rr_pick
  import fifo_sched_pkg::*;
#(
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int QUEUE_BITS = QUEUE_BITS_DEF
) (
  input  logic [NUM_QUEUES-1:0] fifo_empty_i,
  input  logic [QUEUE_BITS-1:0] last_grant_i,
  output logic [QUEUE_BITS-1:0] grant_o,
  output logic                  any_req_o,
  output logic                  prio_o
);

  int idx;

  // Walk downward so the nearest queue above last_grant is written last.
  always_comb begin
    grant_o   = '0;
    any_req_o = |(~fifo_empty_i);
    prio_o    = 1'b0;
    idx       = 0;
    for (int k = NUM_QUEUES; k >= 1; k--) begin
      idx = (int'(last_grant_i) + k) % NUM_QUEUES;
      if (!fifo_empty_i[idx]) begin
        grant_o = QUEUE_BITS'(idx);
      end
    end
`ifdef SCHED_PRIO_EN
    if (!fifo_empty_i[0]) begin
      grant_o = '0;
      prio_o  = 1'b1;
    end
`else
    prio_o = 1'b0;
`endif
  end

endmodule

// File: rtl/fifo_rr_scheduler.sv
// Drains NUM_QUEUES FIFOs one word at a time in round-robin order.
// SCHED_PRIO_EN gives queue 0 strict priority without moving last_grant.
module fifo_rr_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_QUEUES = NUM_QUEUES_DEF,
  parameter int QUEUE_BITS = QUEUE_BITS_DEF
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic                             enable,
  input  logic [NUM_QUEUES-1:0]            fifo_empty,
  output logic [NUM_QUEUES-1:0]            fifo_read_enable,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] fifo_q,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [QUEUE_BITS-1:0]            out_queue,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             busy
);

  state_e                  state_q;
  logic [QUEUE_BITS-1:0]   last_q;
  logic [QUEUE_BITS-1:0]   grant_q;
  logic [NUM_QUEUES-1:0]   rd_en_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [QUEUE_BITS-1:0]   queue_q;
  logic                    valid_q;

  logic [QUEUE_BITS-1:0]   pick;
  logic                    any_req;
  logic                    prio;

  fifo_rr_pick #(
    .NUM_QUEUES (NUM_QUEUES),
    .QUEUE_BITS (QUEUE_BITS)
  ) u_pick (
    .fifo_empty_i (fifo_empty),
    .last_grant_i (last_q),
    .grant_o      (pick),
    .any_req_o    (any_req),
    .prio_o       (prio)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= QUEUE_BITS'(NUM_QUEUES - 1);
      grant_q <= '0;
      rd_en_q <= '0;
      data_q  <= '0;
      queue_q <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (enable && any_req) begin
            rd_en_q <= NUM_QUEUES'(1) << pick;
            grant_q <= pick;
            if (!prio) last_q <= pick;
            state_q <= READ;
          end
        end
        READ: begin
          rd_en_q <= '0;
          state_q <= CAPTURE;
        end
        CAPTURE: begin
          data_q  <= fifo_q[int'(grant_q)*DATA_WIDTH +: DATA_WIDTH];
          queue_q <= grant_q;
          valid_q <= 1'b1;
          state_q <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fifo_read_enable = rd_en_q;
  assign out_data         = data_q;
  assign out_queue        = queue_q;
  assign out_valid        = valid_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_rr_scheduler.sv
// Scoreboard bench: FIFO/arbiter reference model feeds expected words,
// an independent monitor checks them at the output handshake.
module tb_fifo_rr_scheduler;
  import fifo_sched_pkg::*;

  localparam int DW = 32;
  localparam int NQ = 4;
  localparam int QB = 2;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          enable;
  logic [NQ-1:0] fifo_empty;
  logic [NQ-1:0] fifo_read_enable;
  logic [NQ*DW-1:0] fifo_q;
  logic [DW-1:0] out_data;
  logic [QB-1:0] out_queue;
  logic          out_valid;
  logic          out_ready;
  logic          busy;

  fifo_rr_scheduler #(
    .DATA_WIDTH (DW),
    .NUM_QUEUES (NQ),
    .QUEUE_BITS (QB)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .fifo_empty       (fifo_empty),
    .fifo_read_enable (fifo_read_enable),
    .fifo_q           (fifo_q),
    .out_data         (out_data),
    .out_queue        (out_queue),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int            q;
    logic [DW-1:0] d;
    int            vc;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] fq[NQ][$];

  int errors = 0;
  int checks = 0;
  int m_last;
  bit m_idle, prev_en, prev_valid, prev_ready;
  bit saw_strobe, was_valid;
  int en_pct = 100, rdy_pct = 100, fill_pct = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // First non-empty queue above last, wrapping; queue 0 first in prio mode.
  function automatic int ref_pick(int last);
`ifdef SCHED_PRIO_EN
    if (fq[0].size() != 0) return 0;
`endif
    for (int d = 1; d <= NQ; d++) begin
      int q = (last + d) % NQ;
      if (fq[q].size() != 0) return q;
    end
    return -1;
  endfunction

  task automatic fill(int q, logic [DW-1:0] w);
    fq[q].push_back(w);
    fifo_empty[q] = 1'b0;
  endtask

  task automatic model_reset();
    m_last     = NQ - 1;
    m_idle     = 1'b1;
    prev_valid = 1'b0;
    prev_ready = 1'b0;
    sb.delete();
  endtask

  task automatic observe();
    bit any, exp_s, acc, hit0;
    int idx, p;
    logic [DW-1:0] head;
    any = 1'b0;
    for (int i = 0; i < NQ; i++) if (fq[i].size() != 0) any = 1'b1;
    acc   = prev_valid && prev_ready;
    exp_s = m_idle && prev_en && any;
    saw_strobe = (fifo_read_enable != '0);
    chk("strobe_present", 64'(saw_strobe), 64'(exp_s));
    if (saw_strobe) begin
      chk("strobe_onehot", 64'($onehot(fifo_read_enable)), 64'd1);
      idx = 0;
      for (int i = 0; i < NQ; i++) if (fifo_read_enable[i]) idx = i;
      p = ref_pick(m_last);
      chk("grant_queue", 64'(idx), 64'(p));
      chk("grant_nonempty", 64'(fq[idx].size() != 0), 64'd1);
      hit0 = (fq[0].size() != 0);
`ifdef SCHED_PRIO_EN
      if (!hit0) m_last = idx;
`else
      if (hit0 || !hit0) m_last = idx;
`endif
      if (fq[idx].size() != 0) begin
        head = fq[idx].pop_front();
        fifo_q[idx*DW +: DW] = head;
        sb.push_back('{idx, head, cyc + 2});
      end
    end
    m_idle = saw_strobe ? 1'b0 : (acc ? 1'b1 : m_idle);
    chk("busy", 64'(busy), 64'(!m_idle));
  endtask

  task automatic drive();
    enable    = ($urandom_range(0, 99) < en_pct);
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    for (int i = 0; i < NQ; i++)
      if ($urandom_range(0, 99) < fill_pct && fq[i].size() < 6)
        fq[i].push_back($urandom());
    for (int i = 0; i < NQ; i++) fifo_empty[i] = (fq[i].size() == 0);
    prev_en    = enable;
    prev_valid = out_valid;
    prev_ready = out_ready;
  endtask

  task automatic step();
    @(posedge clock);
    #2;
    observe();
    drive();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rd_en"}, 64'(fifo_read_enable), 64'd0);
    chk({tag, "_data"},  64'(out_data),  64'd0);
    chk({tag, "_queue"}, 64'(out_queue), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_busy"},  64'(busy),      64'd0);
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      was_valid = 1'b0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got q=%0d d=%0h want none",
                   out_queue, out_data);
        end else begin
          if (!was_valid) chk("latency", 64'(cyc), 64'(sb[0].vc));
          chk("out_queue", 64'(out_queue), 64'(sb[0].q));
          chk("out_data", 64'(out_data), 64'(sb[0].d));
          if (out_ready) void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && cyc > sb[0].vc) begin
        chk("valid_missing", 64'(out_valid), 64'd1);
      end
      was_valid = out_valid;
    end
  end

  initial begin
    reset_n    = 1'b1;
    enable     = 1'b0;
    out_ready  = 1'b0;
    fifo_empty = '1;
    fifo_q     = '0;
    #3 reset_n = 1'b0;
    #1 chk_zero("por");
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    model_reset();
    drive();

    // All queues loaded, ready always high: strict rotation from queue 0.
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 3; k++) fill(q, $urandom());
    repeat (20) step();
    repeat (40) step();

    // Lone word held back by the consumer.
    rdy_pct = 0;
    fill(2, 32'hDEADBEEF);
    repeat (12) step();
    rdy_pct = 100;
    repeat (6) step();

    // Enable drops right after a grant.
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 3; k++) fill(q, $urandom());
    for (int i = 0; i < 20 && !saw_strobe; i++) step();
    chk("grant_seen_c", 64'(saw_strobe), 64'd1);
    en_pct  = 0;
    enable  = 1'b0;
    prev_en = 1'b0;
    repeat (15) step();

    // Randomised traffic.
    en_pct   = 80;
    rdy_pct  = 70;
    fill_pct = 35;
    repeat (1500) step();

    // Reset while a word is being captured.
    en_pct   = 100;
    rdy_pct  = 100;
    fill_pct = 0;
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 2; k++) fill(q, $urandom());
    repeat (6) step();
    saw_strobe = 1'b0;
    for (int i = 0; i < 20 && !saw_strobe; i++) step();
    chk("grant_seen_e", 64'(saw_strobe), 64'd1);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1 chk_zero("mid");
    sb.delete();
    @(posedge clock);
    #2 reset_n = 1'b1;
    model_reset();
    for (int q = 0; q < NQ; q++) fill(q, $urandom());
    drive();
    repeat (30) step();

    en_pct = 0;
    repeat (10) step();
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_rr_scheduler.md
FIFO_RR_SCHEDULER -- requirements
Module: fifo_rr_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, 32, width of every queue word.
REQ-002 Parameter NUM_QUEUES, 4, number of FIFOs drained (2..16).
REQ-003 Parameter QUEUE_BITS, 2, index width, SHALL equal ceil(log2(NUM_QUEUES)).
REQ-004 clock  input  1  single clock; all logic on posedge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 enable  input  1  high permits new grants.
REQ-007 fifo_empty  input  NUM_QUEUES  empty flag of queue i at bit i.
REQ-008 fifo_read_enable  output  NUM_QUEUES  registered one-hot read strobe to queue i.
REQ-009 fifo_q  input  NUM_QUEUES*DATA_WIDTH  read data; queue i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 out_data  output  DATA_WIDTH  registered forwarded word.
REQ-011 out_queue  output  QUEUE_BITS  source queue index of out_data.
REQ-012 out_valid  output  1  out_data/out_queue valid.
REQ-013 out_ready  input  1  consumer accepts when out_valid and out_ready high at posedge.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, READ, CAPTURE, HOLD.
REQ-016 IDLE: if enable=1 and any fifo_empty bit low, pick grant g, set fifo_read_enable[g]=1, go READ; else stay.
REQ-017 Round-robin pick: first non-empty queue searching upward from last_grant+1, wrapping modulo NUM_QUEUES; last_grant SHALL update to g at the grant edge.
REQ-018 READ: fifo_read_enable held exactly one cycle; cleared on the next edge; go CAPTURE.
REQ-019 CAPTURE: latch fifo_q slice g into out_data, g into out_queue, set out_valid=1, go HOLD.
REQ-020 HOLD: out_data/out_queue stable while out_valid=1; on out_valid&out_ready clear out_valid, go IDLE.
REQ-021 Latency: grant edge to out_valid high = 2 clock edges; minimum 4 cycles per word at out_ready=1.
REQ-022 fifo_empty SHALL be sampled only in IDLE; changes in other states ignored.
REQ-023 enable low outside IDLE: current transaction completes; no new grant until enable high.
REQ-024 All queues empty in IDLE: no strobe, last_grant unchanged.
REQ-025 Only one queue non-empty: it is granted every transaction regardless of last_grant.
REQ-026 fifo_read_enable SHALL never have more than one bit set, and never be set to a queue whose empty flag was high at the grant edge.

Reset
REQ-027 reset_n low SHALL immediately force state=IDLE, fifo_read_enable=0, out_data=0, out_queue=0, out_valid=0, busy=0, last_grant=NUM_QUEUES-1 (queue 0 first after reset).
REQ-028 Reset mid-transaction SHALL drop the in-flight word; no strobe issued after reset_n deasserts until a fresh IDLE grant.

Configuration
REQ-029 Macro SCHED_PRIO_EN: defined -> queue 0, when non-empty in IDLE, SHALL be granted ahead of round-robin order, last_grant not updated by such grants; undefined -> pure round-robin per REQ-017.

Structure
REQ-030 Package fifo_sched_pkg SHALL hold the state enum typedef (IDLE, READ, CAPTURE, HOLD) and the default parameter constants.
REQ-031 Sub-module fifo_rr_pick SHALL compute the combinational next grant and any-request flag from fifo_empty, last_grant (and priority mode); FSM and registers stay in fifo_rr_scheduler.

Verification
REQ-032 Reset, all queues non-empty, out_ready=1 -> out_queue sequence 0,1,2,3,0; one strobe per word; out_data matches each queue's head.
REQ-033 Only queue 2 non-empty, last_grant=3 -> grant 2; strobe bit 2 one cycle; out_valid 2 edges after grant.
REQ-034 out_ready=0 for 5 cycles in HOLD, data 0xDEADBEEF -> out_data stable 0xDEADBEEF, no new strobe; accepted on first ready edge, busy drops next edge.
REQ-035 reset_n pulsed low during CAPTURE -> outputs zero immediately; next grant after release is queue 0.
REQ-036 enable dropped in READ -> word still delivered; no further strobes while enable=0 with all queues non-empty.
REQ-037 SCHED_PRIO_EN defined, queues 0 and 1 always non-empty -> out_queue always 0; undefined -> alternating 0,1.
